// File: rtl/lock_pkg.sv
// Shared types, key codes and sizing helpers for the door-lock sequencer.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK_FP = 3'd1,
    ST_PIN      = 3'd2,
    ST_UNLOCK   = 3'd3,
    ST_LOCKOUT  = 3'd4
  } lock_state_e;

  localparam logic [3:0] KEY_CANCEL    = 4'hF;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  // Width that can hold (max cycles - 1) of every timed state.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic [15:0] pin_mask(input int len);
    return 16'((32'd1 << (4 * len)) - 32'd1);
  endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Sensor/keypad/actuator bundle between the lock sequencer and its surroundings.
interface lock_sequencer_if;

  logic       fp_valid;
  logic [7:0] fp_data;
  logic [7:0] fp_to_cmp;
  logic       cmp_mismatch;
  logic       btn_valid;
  logic [3:0] btn;
  logic       unlock;
  logic       alarm;
  logic       busy;
  logic [1:0] fail_cnt;
  logic [2:0] state_o;

  modport master (
    output fp_valid, fp_data, cmp_mismatch, btn_valid, btn,
    input  fp_to_cmp, unlock, alarm, busy, fail_cnt, state_o
  );

  modport slave (
    input  fp_valid, fp_data, cmp_mismatch, btn_valid, btn,
    output fp_to_cmp, unlock, alarm, busy, fail_cnt, state_o
  );

endinterface

// File: rtl/lock_pin_collector.sv
// Keypad PIN collector: shifts digits in, tracks the digit index and flags done/ok/cancel/timeout.
module lock_pin_collector
  import lock_pkg::*;
#(
  parameter int          PIN_LEN  = 4,
  parameter logic [15:0] PIN_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_active,
  input  logic       i_clear,
  input  logic       i_btn_valid,
  input  logic [3:0] i_btn,
  input  logic       i_timer_zero,
  output logic       o_digit,
  output logic       o_done,
  output logic       o_ok,
  output logic       o_cancel,
  output logic       o_timeout
);

  localparam logic [15:0] MASK     = pin_mask(PIN_LEN);
  localparam logic [1:0]  LAST_IDX = 2'(PIN_LEN - 1);

  logic [1:0]  r_index;
  logic [11:0] r_shift;
  logic [15:0] w_shift_next;
  logic        w_key_valid;

  assign w_key_valid  = i_active & i_btn_valid;
  assign o_digit      = w_key_valid && (i_btn <= KEY_DIGIT_MAX);
  assign o_cancel     = w_key_valid && (i_btn == KEY_CANCEL);
  assign o_done       = o_digit && (r_index == LAST_IDX);
  assign w_shift_next = {r_shift, i_btn};
  // Older digits from a previous attempt fall outside the mask.
  assign o_ok         = ((w_shift_next & MASK) == (PIN_CODE & MASK));
  assign o_timeout    = i_active && i_timer_zero && !o_digit && !o_cancel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= 2'd0;
      r_shift <= 12'd0;
    end else if (i_clear) begin
      r_index <= 2'd0;
      r_shift <= 12'd0;
    end else if (o_digit) begin
      r_shift <= w_shift_next[11:0];
      r_index <= o_done ? 2'd0 : r_index + 2'd1;
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// Door-lock sequencer: fingerprint check, optional keypad PIN (LOCK_PIN_EN), unlock pulse and lockout.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int          PIN_LEN        = 4,
  parameter logic [15:0] PIN_CODE       = 16'h1234,
  parameter int          UNLOCK_CYCLES  = 8,
  parameter int          LOCKOUT_CYCLES = 16,
  parameter int          MAX_FAIL       = 3,
  parameter int          TIMEOUT_CYCLES = 32
) (
  input logic             clk,
  input logic             rst_n,
  lock_sequencer_if.slave bus
);

  localparam int TW = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    FAIL_LIMIT   = 2'(MAX_FAIL);

  lock_state_e   r_state;
  lock_state_e   w_next_state;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [1:0]    r_fail_cnt;
  logic [1:0]    w_fail_next;
  logic [1:0]    w_fail_inc;
  logic [7:0]    r_fp;
  logic          r_unlock;
  logic          r_alarm;
  logic          r_busy;
  logic          w_capture;
  logic          w_fail_event;
  logic          w_timer_zero;

  assign w_fail_inc   = r_fail_cnt + 2'd1;
  assign w_timer_zero = (r_timer == '0);

`ifdef LOCK_PIN_EN
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic w_pin_clear;
  logic w_pin_digit;
  logic w_pin_done;
  logic w_pin_ok;
  logic w_pin_cancel;
  logic w_pin_timeout;

  lock_pin_collector #(
    .PIN_LEN  (PIN_LEN),
    .PIN_CODE (PIN_CODE)
  ) u_pin (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_active     (r_state == ST_PIN),
    .i_clear      (w_pin_clear),
    .i_btn_valid  (bus.btn_valid),
    .i_btn        (bus.btn),
    .i_timer_zero (w_timer_zero),
    .o_digit      (w_pin_digit),
    .o_done       (w_pin_done),
    .o_ok         (w_pin_ok),
    .o_cancel     (w_pin_cancel),
    .o_timeout    (w_pin_timeout)
  );
`else
  // Keypad and PIN configuration are deliberately unused in this build.
  logic        w_unused_btn;
  logic [15:0] w_unused_cfg;
  assign w_unused_btn = ^{bus.btn_valid, bus.btn};
  assign w_unused_cfg = PIN_CODE ^ 16'(PIN_LEN);
`endif

  always_comb begin
    w_next_state = r_state;
    w_timer_next = r_timer;
    w_fail_next  = r_fail_cnt;
    w_capture    = 1'b0;
    w_fail_event = 1'b0;
`ifdef LOCK_PIN_EN
    w_pin_clear  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.fp_valid) begin
          w_capture    = 1'b1;
          w_next_state = ST_CHECK_FP;
        end
      end
      ST_CHECK_FP: begin
        if (bus.cmp_mismatch) begin
          w_fail_event = 1'b1;
        end else begin
`ifdef LOCK_PIN_EN
          w_next_state = ST_PIN;
          w_pin_clear  = 1'b1;
          w_timer_next = TIMEOUT_LOAD;
`else
          w_next_state = ST_UNLOCK;
          w_timer_next = UNLOCK_LOAD;
          w_fail_next  = 2'd0;
`endif
        end
      end
`ifdef LOCK_PIN_EN
      ST_PIN: begin
        if (w_pin_digit) begin
          w_timer_next = TIMEOUT_LOAD;
          if (w_pin_done) begin
            if (w_pin_ok) begin
              w_next_state = ST_UNLOCK;
              w_timer_next = UNLOCK_LOAD;
              w_fail_next  = 2'd0;
            end else begin
              w_fail_event = 1'b1;
            end
          end
        end else if (w_pin_cancel) begin
          w_next_state = ST_IDLE;
        end else if (w_pin_timeout) begin
          w_fail_event = 1'b1;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
`endif
      ST_UNLOCK: begin
        if (w_timer_zero) w_next_state = ST_IDLE;
        else              w_timer_next = r_timer - TW'(1);
      end
      ST_LOCKOUT: begin
        if (w_timer_zero) begin
          w_next_state = ST_IDLE;
          w_fail_next  = 2'd0;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    // Every failure path funnels through here so counting and lockout stay in one place.
    if (w_fail_event) begin
      w_fail_next = w_fail_inc;
      if (w_fail_inc == FAIL_LIMIT) begin
        w_next_state = ST_LOCKOUT;
        w_timer_next = LOCKOUT_LOAD;
      end else begin
        w_next_state = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_fail_cnt <= 2'd0;
      r_fp       <= 8'd0;
      r_unlock   <= 1'b0;
      r_alarm    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_timer    <= w_timer_next;
      r_fail_cnt <= w_fail_next;
      if (w_capture) r_fp <= bus.fp_data;
      r_unlock   <= (w_next_state == ST_UNLOCK);
      r_alarm    <= (w_next_state == ST_LOCKOUT);
      r_busy     <= (w_next_state != ST_IDLE);
    end
  end

  assign bus.fp_to_cmp = r_fp;
  assign bus.unlock    = r_unlock;
  assign bus.alarm     = r_alarm;
  assign bus.busy      = r_busy;
  assign bus.fail_cnt  = r_fail_cnt;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer; exercises the PIN stage when LOCK_PIN_EN is defined.
module tb_lock_sequencer;
  import lock_pkg::*;

  logic       clk;
  logic       rst_n;
  int         compared   = 0;
  int         mismatched = 0;
  int         n;
  logic [7:0] lastFp;

  lock_sequencer_if lif();

  // Comparator stand-in: only sample 97 is the enrolled finger.
  assign lif.cmp_mismatch = (lif.fp_to_cmp != 8'd97);

  lock_sequencer #(
    .PIN_LEN        (4),
    .PIN_CODE       (16'h1234),
    .UNLOCK_CYCLES  (8),
    .LOCKOUT_CYCLES (16),
    .MAX_FAIL       (3),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fpv, input logic [7:0] fpd,
                               input logic bv, input logic [3:0] b);
    lif.fp_valid  = fpv;
    lif.fp_data   = fpd;
    lif.btn_valid = bv;
    lif.btn       = b;
    @(posedge clk);
    #1;
    lif.fp_valid  = 1'b0;
    lif.btn_valid = 1'b0;
  endtask

  task automatic startFp(input logic [7:0] data);
    applyStimulus(1'b1, data, 1'b0, 4'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
  endtask

  task automatic pressKey(input logic [3:0] k);
    applyStimulus(1'b0, 8'd0, 1'b1, k);
  endtask

  task automatic enterUnlock();
    startFp(8'd97);
`ifdef LOCK_PIN_EN
    pressKey(4'd1);
    pressKey(4'd2);
    pressKey(4'd3);
    pressKey(4'd4);
`endif
  endtask

  task automatic countHigh(input logic useAlarm, input logic [7:0] injectData, output int cnt);
    cnt = 0;
    while (cnt < 64 && (useAlarm ? lif.alarm : lif.unlock)) begin
      cnt++;
      applyStimulus(cnt == 2, injectData, 1'b1, 4'd1);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    lif.fp_valid  = 1'b0;
    lif.fp_data   = 8'd0;
    lif.btn_valid = 1'b0;
    lif.btn       = 4'd0;
    #2;
    checkOutput("rst_state", lif.state_o, 0);
    checkOutput("rst_unlock", lif.unlock, 0);
    checkOutput("rst_alarm", lif.alarm, 0);
    checkOutput("rst_busy", lif.busy, 0);
    checkOutput("rst_fail", lif.fail_cnt, 0);
    checkOutput("rst_fp", lif.fp_to_cmp, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);

    pressKey(4'd1);
    checkOutput("idle_btn_state", lif.state_o, 0);
    checkOutput("idle_btn_busy", lif.busy, 0);

    applyStimulus(1'b1, 8'd5, 1'b0, 4'd0);
    checkOutput("bad1_chk_state", lif.state_o, 1);
    checkOutput("bad1_chk_busy", lif.busy, 1);
    checkOutput("bad1_fp", lif.fp_to_cmp, 5);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    checkOutput("bad1_state", lif.state_o, 0);
    checkOutput("bad1_fail", lif.fail_cnt, 1);
    checkOutput("bad1_unlock", lif.unlock, 0);

    startFp(8'd97);
`ifdef LOCK_PIN_EN
    checkOutput("happy_pin_state", lif.state_o, 2);
    pressKey(4'd1);
    pressKey(4'd2);
    pressKey(4'd3);
    checkOutput("happy_3keys_state", lif.state_o, 2);
    checkOutput("happy_3keys_unlock", lif.unlock, 0);
    pressKey(4'd4);
`endif
    checkOutput("happy_state", lif.state_o, 3);
    checkOutput("happy_unlock", lif.unlock, 1);
    checkOutput("happy_fail", lif.fail_cnt, 0);
    countHigh(1'b0, 8'd55, n);
    checkOutput("unlock_len", n, 8);
    checkOutput("unlock_end_state", lif.state_o, 0);
    checkOutput("unlock_end_busy", lif.busy, 0);
    checkOutput("unlock_fp_ignored", lif.fp_to_cmp, 97);

`ifdef LOCK_PIN_EN
    startFp(8'd6);
    checkOutput("f1_fail", lif.fail_cnt, 1);
    startFp(8'd97);
    pressKey(4'd1);
    pressKey(4'd2);
    pressKey(4'd3);
    pressKey(4'd5);
    checkOutput("wrongpin_state", lif.state_o, 0);
    checkOutput("wrongpin_fail", lif.fail_cnt, 2);
    checkOutput("wrongpin_unlock", lif.unlock, 0);
    startFp(8'd97);
    checkOutput("tmo_enter_state", lif.state_o, 2);
    n = 0;
    while (lif.state_o == 3'd2 && n < 60) begin
      applyStimulus(1'b0, 8'd0, (n == 10), 4'hA);
      n++;
    end
    checkOutput("tmo_cycles", n, 32);
    lastFp = 8'd97;
`else
    startFp(8'd6);
    checkOutput("f1_fail", lif.fail_cnt, 1);
    startFp(8'd7);
    checkOutput("f2_state", lif.state_o, 0);
    checkOutput("f2_fail", lif.fail_cnt, 2);
    startFp(8'd8);
    lastFp = 8'd8;
`endif
    checkOutput("lock_state", lif.state_o, 4);
    checkOutput("lock_alarm", lif.alarm, 1);
    checkOutput("lock_fail", lif.fail_cnt, 3);
    checkOutput("lock_busy", lif.busy, 1);
    countHigh(1'b1, 8'd200, n);
    checkOutput("alarm_len", n, 16);
    checkOutput("lock_end_state", lif.state_o, 0);
    checkOutput("lock_end_fail", lif.fail_cnt, 0);
    checkOutput("lock_fp_ignored", lif.fp_to_cmp, lastFp);

`ifdef LOCK_PIN_EN
    startFp(8'd9);
    checkOutput("cancel_pre_fail", lif.fail_cnt, 1);
    startFp(8'd97);
    pressKey(4'd1);
    pressKey(4'd2);
    pressKey(4'hF);
    checkOutput("cancel_state", lif.state_o, 0);
    checkOutput("cancel_fail", lif.fail_cnt, 1);
    checkOutput("cancel_busy", lif.busy, 0);
`endif

    enterUnlock();
    checkOutput("rmid_unlock_on", lif.unlock, 1);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_unlock", lif.unlock, 0);
    checkOutput("rmid_state", lif.state_o, 0);
    checkOutput("rmid_busy", lif.busy, 0);
    checkOutput("rmid_fp", lif.fp_to_cmp, 0);
    checkOutput("rmid_fail", lif.fail_cnt, 0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 4'd0);
    checkOutput("post_rst_state", lif.state_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
